ahb_timer_seq: RTL and testbench



---
 rtl/ahb_timer_pkg.sv | 47 ++++
 rtl/ahb_single_wr.sv | 89 ++++++++
 rtl/ahb_timer_seq.sv | 170 +++++++++++++++++
 tb/tb_ahb_timer_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_timer_pkg.sv
// Shared encodings for the ahb_timer peripheral and its AHB-Lite sequencer:
// bus encodings, timer register map, CTRL bits, command ops and FSM states.
package ahb_timer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [7:0] REG_CTRL_OFS  = 8'h0;
    localparam logic [7:0] REG_COUNT_OFS = 8'h4;
    localparam logic [7:0] REG_VALUE_OFS = 8'h8;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_IE_BIT   = 1;
    localparam int CTRL_PEND_BIT = 2;

    // PEND is write-1-to-clear, so both constants also acknowledge a pending expiry.
    localparam logic [31:0] CTRL_ARM    = (32'h1 << CTRL_EN_BIT) | (32'h1 << CTRL_IE_BIT)
                                        | (32'h1 << CTRL_PEND_BIT);
    localparam logic [31:0] CTRL_DISARM = (32'h1 << CTRL_PEND_BIT);

    typedef enum logic [1:0] {
        OP_START_ONESHOT  = 2'b00,
        OP_START_PERIODIC = 2'b01,
        OP_STOP           = 2'b10,
        OP_RESERVED       = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_BUSY,
        SEQ_ARMED
    } seq_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_GAP
    } wr_state_e;

    function automatic logic is_start_op(input cmd_op_e op);
        return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
    endfunction

endpackage

// File: rtl/ahb_single_wr.sv
// One AHB-Lite single write: address phase, data phase, then a mandatory idle gap.
// done_o is high during the gap so the caller can chain the next write back-to-back.
module ahb_single_wr
    import ahb_timer_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              hready_i,
    input  logic              hresp_i,
    output logic [AWIDTH-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [DWIDTH-1:0] hwdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    wr_state_e         state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (start_i) begin
                    state_d = WR_ADDR;
                    addr_d  = addr_i;
                    data_d  = data_i;
                end
            end
            WR_ADDR: begin
                if (hready_i) state_d = WR_DATA;
            end
            WR_DATA: begin
                // An error response skips the gap; the caller abandons the sequence.
                if (hready_i) begin
                    if (hresp_i) begin
                        err_o   = 1'b1;
                        state_d = WR_IDLE;
                    end else begin
                        state_d = WR_GAP;
                    end
                end
            end
            WR_GAP: begin
                done_o = 1'b1;
                if (start_i) begin
                    state_d = WR_ADDR;
                    addr_d  = addr_i;
                    data_d  = data_i;
                end else begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    assign haddr_o  = (state_q == WR_ADDR) ? addr_q : '0;
    assign htrans_o = (state_q == WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite_o = (state_q == WR_ADDR);
    assign hwdata_o = (state_q == WR_DATA) ? data_q : '0;
    assign busy_o   = (state_q != WR_IDLE);

endmodule

// File: rtl/ahb_timer_seq.sv
// AHB-Lite master that programs the ahb_timer for one client: START/STOP commands
// become register writes, and each timer expiry is acknowledged and reported as a tick.
module ahb_timer_seq
    import ahb_timer_pkg::*;
#(
    parameter int                AWIDTH     = 32,
    parameter int                DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] TIMER_BASE = 32'h4000_0000
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [DWIDTH-1:0] cmd_period_i,
    input  logic              timer_irq_i,
    output logic [AWIDTH-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic [DWIDTH-1:0] hwdata_o,
    input  logic              hready_i,
    input  logic              hresp_i,
    output logic              tick_o,
    output logic              armed_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [AWIDTH-1:0] CTRL_ADDR  = TIMER_BASE + AWIDTH'(REG_CTRL_OFS);
    localparam logic [AWIDTH-1:0] VALUE_ADDR = TIMER_BASE + AWIDTH'(REG_VALUE_OFS);
    localparam logic [DWIDTH-1:0] ARM_DATA   = DWIDTH'(CTRL_ARM);
    localparam logic [DWIDTH-1:0] STOP_DATA  = DWIDTH'(CTRL_DISARM);

    seq_state_e        state_q, state_d;
    logic              more_q, more_d;
    logic [DWIDTH-1:0] next_data_q, next_data_d;
    logic              end_armed_q, end_armed_d;
    logic              periodic_q, periodic_d;
    logic              err_q, err_d;
    logic              tick_q, tick_d;

    logic              wr_start;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              wr_busy, wr_done, wr_err;

    cmd_op_e           op;
    logic              cmd_accept;
    logic              irq_take;
    logic [DWIDTH-1:0] period_fixed;

    assign op           = cmd_op_e'(cmd_op_i);
    assign period_fixed = (cmd_period_i == '0) ? DWIDTH'(1) : cmd_period_i;
    assign cmd_ready_o  = !hreset && ((state_q == SEQ_IDLE) ||
                                      ((state_q == SEQ_ARMED) && !timer_irq_i));
    assign cmd_accept   = cmd_valid_i && cmd_ready_o;
    assign irq_take     = (state_q == SEQ_ARMED) && timer_irq_i;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= SEQ_IDLE;
            more_q      <= 1'b0;
            next_data_q <= '0;
            end_armed_q <= 1'b0;
            periodic_q  <= 1'b0;
            err_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            more_q      <= more_d;
            next_data_q <= next_data_d;
            end_armed_q <= end_armed_d;
            periodic_q  <= periodic_d;
            err_q       <= err_d;
            tick_q      <= tick_d;
        end
    end

    // The write list: the first write goes straight to the writer, the second (always
    // CTRL) waits in next_data_q and is launched from the writer's gap cycle.
    always_comb begin
        state_d     = state_q;
        more_d      = more_q;
        next_data_d = next_data_q;
        end_armed_d = end_armed_q;
        periodic_d  = periodic_q;
        err_d       = err_q;
        tick_d      = 1'b0;
        wr_start    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        case (state_q)
            SEQ_IDLE, SEQ_ARMED: begin
                if (irq_take) begin
                    tick_d      = 1'b1;
                    wr_start    = 1'b1;
                    wr_addr     = CTRL_ADDR;
                    wr_data     = periodic_q ? ARM_DATA : STOP_DATA;
                    more_d      = 1'b0;
                    end_armed_d = periodic_q;
                    state_d     = SEQ_BUSY;
                end else if (cmd_accept) begin
                    err_d    = 1'b0;
                    wr_start = 1'b1;
                    state_d  = SEQ_BUSY;
                    if (is_start_op(op)) begin
                        wr_addr     = VALUE_ADDR;
                        wr_data     = period_fixed;
                        more_d      = 1'b1;
                        next_data_d = ARM_DATA;
                        end_armed_d = 1'b1;
                        periodic_d  = (op == OP_START_PERIODIC);
                    end else begin
                        wr_addr     = CTRL_ADDR;
                        wr_data     = STOP_DATA;
                        more_d      = 1'b0;
                        end_armed_d = 1'b0;
                    end
                end
            end
            SEQ_BUSY: begin
                if (wr_err) begin
                    err_d   = 1'b1;
                    more_d  = 1'b0;
                    state_d = SEQ_IDLE;
                end else if (wr_done) begin
                    if (more_q) begin
                        wr_start = 1'b1;
                        wr_addr  = CTRL_ADDR;
                        wr_data  = next_data_q;
                        more_d   = 1'b0;
                    end else begin
                        state_d = end_armed_q ? SEQ_ARMED : SEQ_IDLE;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    ahb_single_wr #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_wr (
        .hclk     (hclk),
        .hreset   (hreset),
        .start_i  (wr_start),
        .addr_i   (wr_addr),
        .data_i   (wr_data),
        .hready_i (hready_i),
        .hresp_i  (hresp_i),
        .haddr_o  (haddr_o),
        .htrans_o (htrans_o),
        .hwrite_o (hwrite_o),
        .hwdata_o (hwdata_o),
        .busy_o   (wr_busy),
        .done_o   (wr_done),
        .err_o    (wr_err)
    );

    assign hsize_o  = HSIZE_WORD;
    assign hburst_o = HBURST_SINGLE;
    assign tick_o   = tick_q;
    assign armed_o  = (state_q == SEQ_ARMED);
    assign busy_o   = wr_busy;
    assign err_o    = err_q;

endmodule

// File: tb/tb_ahb_timer_seq.sv
// Bench for ahb_timer_seq: expected bus writes are queued as commands and irqs are
// driven, and a bus monitor pops and compares them as each data phase completes.
module tb_ahb_timer_seq;

    localparam logic [31:0] CTRL_A  = 32'h4000_0000;
    localparam logic [31:0] VALUE_A = 32'h4000_0008;
    localparam logic [1:0]  NONSEQ  = 2'b10;
    localparam logic [1:0]  IDLE_T  = 2'b00;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [31:0] cmd_period_i = '0;
    logic        timer_irq_i = 1'b0;
    logic [31:0] haddr_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [31:0] hwdata_o;
    logic        hready_i = 1'b1;
    logic        hresp_i = 1'b0;
    logic        tick_o;
    logic        armed_o;
    logic        busy_o;
    logic        err_o;

    int  errors = 0;
    int  checks = 0;
    wr_t expq[$];

    ahb_timer_seq dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_period_i (cmd_period_i),
        .timer_irq_i  (timer_irq_i),
        .haddr_o      (haddr_o),
        .htrans_o     (htrans_o),
        .hwrite_o     (hwrite_o),
        .hsize_o      (hsize_o),
        .hburst_o     (hburst_o),
        .hwdata_o     (hwdata_o),
        .hready_i     (hready_i),
        .hresp_i      (hresp_i),
        .tick_o       (tick_o),
        .armed_o      (armed_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 hclk = ~hclk;

    // Bus monitor: records each accepted address phase and scores it at data completion.
    logic        pend = 1'b0;
    logic [31:0] pendAddr = '0;
    logic        pendWrite = 1'b0;
    always @(negedge hclk) begin
        if (pend && hready_i) begin
            pend = 1'b0;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, none expected",
                         pendAddr, hwdata_o);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if (pendAddr !== e.addr || hwdata_o !== e.data || pendWrite !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL bus_write: got addr=%h data=%h write=%b, exp addr=%h data=%h write=1",
                             pendAddr, hwdata_o, pendWrite, e.addr, e.data);
                end
            end
        end
        if (htrans_o == NONSEQ && hready_i) begin
            pend      = 1'b1;
            pendAddr  = haddr_o;
            pendWrite = hwrite_o;
        end
        if (hreset) pend = 1'b0;
    end

    // Drives one command until accepted, queueing the writes it should produce.
    // Returns 1ns into cycle 1 (cycle 0 being the accepting cycle).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] period,
                                 input bit onlyFirst);
        bit accepted = 0;
        cmd_valid_i  = 1'b1;
        cmd_op_i     = op;
        cmd_period_i = period;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge hclk);
            if (cmd_ready_o === 1'b1) begin
                accepted = 1;
                if (op == 2'b00 || op == 2'b01) begin
                    expq.push_back(wr_t'{addr: VALUE_A, data: (period == 0) ? 32'd1 : period});
                    if (!onlyFirst) expq.push_back(wr_t'{addr: CTRL_A, data: 32'h7});
                end else begin
                    expq.push_back(wr_t'{addr: CTRL_A, data: 32'h4});
                end
            end
            @(posedge hclk); #1;
        end
        cmd_valid_i = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept_timeout: got ready=0 for 20 cycles, exp ready=1");
        end
    endtask

    task automatic irqAck(input logic [31:0] ackData, input logic armedAfter);
        timer_irq_i = 1'b1;
        expq.push_back(wr_t'{addr: CTRL_A, data: ackData});
        @(negedge hclk);
        checks++;
        if (cmd_ready_o !== 1'b0 || tick_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_cycle: got ready=%b tick=%b, exp ready=0 tick=0", cmd_ready_o, tick_o);
        end
        @(posedge hclk); #1;
        @(negedge hclk);
        checks++;
        if (tick_o !== 1'b1 || htrans_o !== NONSEQ || haddr_o !== CTRL_A) begin
            errors++;
            $display("[TB] FAIL ack_addr: got tick=%b htrans=%b haddr=%h, exp tick=1 htrans=10 haddr=%h",
                     tick_o, htrans_o, haddr_o, CTRL_A);
        end
        @(posedge hclk); #1;
        @(negedge hclk);
        checks++;
        if (tick_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tick_width: got tick=%b, exp 0", tick_o);
        end
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        timer_irq_i = 1'b0;
        @(negedge hclk);
        checks++;
        if (armed_o !== armedAfter || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_ack: got armed=%b busy=%b, exp armed=%b busy=0",
                     armed_o, busy_o, armedAfter);
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        @(negedge hclk);
        checks++;
        if (htrans_o !== IDLE_T || haddr_o !== 0 || hwdata_o !== 0 || hwrite_o !== 0 ||
            tick_o !== 0 || armed_o !== 0 || busy_o !== 0 || err_o !== 0 || cmd_ready_o !== 0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got htrans=%b haddr=%h hwdata=%h hwrite=%b tick=%b armed=%b busy=%b err=%b ready=%b, exp all 0",
                     htrans_o, haddr_o, hwdata_o, hwrite_o, tick_o, armed_o, busy_o, err_o, cmd_ready_o);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        checks++;
        if (cmd_ready_o !== 1'b1 || hsize_o !== 3'b010 || hburst_o !== 3'b000 || htrans_o !== IDLE_T) begin
            errors++;
            $display("[TB] FAIL after_reset: got ready=%b hsize=%b hburst=%b htrans=%b, exp 1 010 000 00",
                     cmd_ready_o, hsize_o, hburst_o, htrans_o);
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_periodic();
        applyStimulus(2'b01, 32'd5, 0);
        @(negedge hclk);
        checks++;
        if (htrans_o !== NONSEQ || haddr_o !== VALUE_A || hwrite_o !== 1'b1 || busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL periodic_c1: got htrans=%b haddr=%h hwrite=%b busy=%b ready=%b, exp 10 %h 1 1 0",
                     htrans_o, haddr_o, hwrite_o, busy_o, cmd_ready_o, VALUE_A);
        end
        @(negedge hclk);
        checks++;
        if (htrans_o !== IDLE_T || hwdata_o !== 32'd5 || haddr_o !== 0) begin
            errors++;
            $display("[TB] FAIL periodic_c2: got htrans=%b hwdata=%h haddr=%h, exp 00 5 0", htrans_o, hwdata_o, haddr_o);
        end
        repeat (4) @(negedge hclk);
        checks++;
        if (armed_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL periodic_c6: got armed=%b busy=%b, exp armed=0 busy=1", armed_o, busy_o);
        end
        @(negedge hclk);
        checks++;
        if (armed_o !== 1'b1 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL periodic_c7: got armed=%b busy=%b ready=%b, exp 1 0 1", armed_o, busy_o, cmd_ready_o);
        end
        @(posedge hclk); #1;
        irqAck(32'h7, 1'b1);
        irqAck(32'h7, 1'b1);
    endtask

    task automatic test_stop();
        applyStimulus(2'b10, 32'd0, 0);
        @(negedge hclk);
        checks++;
        if (haddr_o !== CTRL_A || armed_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_c1: got haddr=%h armed=%b busy=%b, exp %h 0 1", haddr_o, armed_o, busy_o, CTRL_A);
        end
        repeat (3) @(negedge hclk);
        checks++;
        if (busy_o !== 1'b0 || armed_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_c4: got busy=%b armed=%b ready=%b, exp 0 0 1", busy_o, armed_o, cmd_ready_o);
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_oneshot();
        applyStimulus(2'b00, 32'd3, 0);
        repeat (7) @(negedge hclk);
        checks++;
        if (armed_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oneshot_armed: got armed=%b, exp 1", armed_o);
        end
        @(posedge hclk); #1;
        irqAck(32'h4, 1'b0);
        timer_irq_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            checks++;
            if (tick_o !== 1'b0 || htrans_o !== IDLE_T || busy_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL oneshot_ignore_irq: got tick=%b htrans=%b busy=%b, exp 0 00 0", tick_o, htrans_o, busy_o);
            end
            @(posedge hclk); #1;
        end
        timer_irq_i = 1'b0;
    endtask

    task automatic test_period_zero_then_stop();
        applyStimulus(2'b01, 32'd0, 0);
        repeat (7) @(negedge hclk);
        checks++;
        if (armed_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_period_armed: got armed=%b, exp 1", armed_o);
        end
        @(posedge hclk); #1;
        test_stop();
    endtask

    task automatic test_wait_states();
        logic        hr   [12] = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [31:0] eAddr[12] = '{VALUE_A, VALUE_A, VALUE_A, VALUE_A, 0, 0, 0, 0, CTRL_A, 0, 0, 0};
        logic [31:0] eData[12] = '{0, 0, 0, 0, 32'd9, 32'd9, 32'd9, 0, 0, 32'h7, 0, 0};
        applyStimulus(2'b00, 32'd9, 0);
        for (int c = 0; c < 12; c++) begin
            hready_i = hr[c];
            @(negedge hclk);
            checks++;
            if (haddr_o !== eAddr[c] || hwdata_o !== eData[c] ||
                htrans_o !== ((eAddr[c] != 0) ? NONSEQ : IDLE_T) || busy_o !== (c != 11) || armed_o !== (c == 11)) begin
                errors++;
                $display("[TB] FAIL wait_state_c%0d: got haddr=%h hwdata=%h htrans=%b busy=%b armed=%b, exp haddr=%h hwdata=%h",
                         c + 1, haddr_o, hwdata_o, htrans_o, busy_o, armed_o, eAddr[c], eData[c]);
            end
            @(posedge hclk); #1;
        end
        hready_i = 1'b1;
        test_stop();
    endtask

    task automatic test_error();
        applyStimulus(2'b01, 32'd6, 1);
        @(posedge hclk); #1;
        hresp_i = 1'b1;
        @(posedge hclk); #1;
        hresp_i = 1'b0;
        @(negedge hclk);
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b1 || armed_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL error_abort: got busy=%b err=%b armed=%b ready=%b, exp 0 1 0 1",
                     busy_o, err_o, armed_o, cmd_ready_o);
        end
        repeat (3) @(negedge hclk);
        checks++;
        if (htrans_o !== IDLE_T || err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL error_sticky: got htrans=%b err=%b, exp 00 1", htrans_o, err_o);
        end
        @(posedge hclk); #1;
        applyStimulus(2'b00, 32'd2, 0);
        @(negedge hclk);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_clear: got err=%b, exp 0", err_o);
        end
        repeat (6) @(negedge hclk);
        @(posedge hclk); #1;
        test_stop();
    endtask

    task automatic test_back_to_back();
        bit accepted = 0;
        int accIdx = -1;
        applyStimulus(2'b01, 32'd4, 0);
        repeat (7) @(negedge hclk);
        @(posedge hclk); #1;
        timer_irq_i  = 1'b1;
        cmd_valid_i  = 1'b1;
        cmd_op_i     = 2'b10;
        cmd_period_i = '0;
        expq.push_back(wr_t'{addr: CTRL_A, data: 32'h7});
        for (int i = 0; i < 16 && !accepted; i++) begin
            @(negedge hclk);
            if (i == 1) begin
                checks++;
                if (tick_o !== 1'b1 || haddr_o !== CTRL_A) begin
                    errors++;
                    $display("[TB] FAIL collide_tick: got tick=%b haddr=%h, exp 1 %h", tick_o, haddr_o, CTRL_A);
                end
            end
            if (cmd_ready_o === 1'b1) begin
                accepted = 1;
                accIdx   = i;
                expq.push_back(wr_t'{addr: CTRL_A, data: 32'h4});
            end
            @(posedge hclk); #1;
            if (i == 3) timer_irq_i = 1'b0;
        end
        cmd_valid_i = 1'b0;
        checks++;
        if (accIdx != 4) begin
            errors++;
            $display("[TB] FAIL collide_accept: got accept cycle=%0d, exp 4", accIdx);
        end
        repeat (4) @(negedge hclk);
        checks++;
        if (busy_o !== 1'b0 || armed_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collide_stop: got busy=%b armed=%b, exp 0 0", busy_o, armed_o);
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_reset_mid_transfer();
        applyStimulus(2'b01, 32'd8, 1);
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        checks++;
        if (htrans_o !== IDLE_T || haddr_o !== 0 || hwdata_o !== 0 || hwrite_o !== 0 || tick_o !== 0 ||
            armed_o !== 0 || busy_o !== 0 || err_o !== 0 || cmd_ready_o !== 0) begin
            errors++;
            $display("[TB] FAIL reset_in_data: got htrans=%b haddr=%h hwdata=%h hwrite=%b tick=%b armed=%b busy=%b err=%b ready=%b, exp all 0",
                     htrans_o, haddr_o, hwdata_o, hwrite_o, tick_o, armed_o, busy_o, err_o, cmd_ready_o);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_stop();
        test_oneshot();
        test_period_zero_then_stop();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_reset_mid_transfer();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL writes_outstanding: got %0d unwritten, exp 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
